// File: rtl/demog_pkg.sv
// Shared types and constants for the demog1 exhaustive sweep checker.
// Contents: FSM state enum, vector width/count, default truth table (3-input NAND),
// settle counter width.
package demog_pkg;

    localparam int unsigned VEC_W    = 3;
    localparam int unsigned NUM_VEC  = 8;
    localparam int unsigned SETTLE_W = 4;

    localparam logic [NUM_VEC-1:0] DEFAULT_TT = 8'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/demog_settle_timer.sv
// Loadable down-counter that times how long each vector settles before sampling.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_load       load i_load_val (has priority over i_en)
//   i_en         decrement while non-zero
//   i_load_val   reload value
//   o_zero_c     combinational flag: count is zero
module demog_settle_timer
    import demog_pkg::*;
#(
    parameter int unsigned W = SETTLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_load_val,
    output logic         o_zero_c
);

    logic [W-1:0] r_cnt;

    // Down-counter; holds at zero until reloaded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/demog_sweep_checker.sv
// Exhaustive self-checking sweep of the demog1 gate: drives all 8 {a,b,c}
// combinations, holds each for SETTLE_CYC cycles, samples dut_d and compares it
// with TRUTH_TABLE[{a,b,c}]. Reports a saturating mismatch count, the first
// failing vector and a pass flag.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a sweep (sampled only in IDLE)
//   dut_a/dut_b/dut_c       registered gate stimulus
//   dut_d                   gate output under check
//   busy, done, pass        status (done is a one-cycle pulse)
//   err_cnt                 saturating mismatch count
//   first_err_vec/_valid    first failing {a,b,c}
// Optional build macro DEMOG_CONT_SWEEP_EN: restart a new sweep straight from
// DONE, forever, ignoring start.
module demog_sweep_checker
    import demog_pkg::*;
#(
    parameter logic [NUM_VEC-1:0] TRUTH_TABLE = DEFAULT_TT,
    parameter int unsigned        SETTLE_CYC  = 2,
    parameter int unsigned        ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 dut_a,
    output logic                 dut_b,
    output logic                 dut_c,
    input  logic                 dut_d,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [VEC_W-1:0]     first_err_vec,
    output logic                 first_err_valid
);

    localparam logic [VEC_W-1:0]    LAST_VEC   = VEC_W'(NUM_VEC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_RLD = SETTLE_W'(SETTLE_CYC - 1);

    state_e                r_state;
    logic [VEC_W-1:0]      r_vec;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic [VEC_W-1:0]      r_first_vec;
    logic                  r_first_valid;

    logic                  w_mismatch;
    logic [ERR_CNT_W-1:0]  w_err_next;
    logic                  w_tmr_load;
    logic                  w_tmr_en;
    logic                  w_tmr_zero;

    // Case-inequality so an X/Z gate output is reported as a mismatch
    assign w_mismatch = (dut_d !== TRUTH_TABLE[r_vec]);
    assign w_err_next = (w_mismatch && !(&r_err_cnt)) ? r_err_cnt + ERR_CNT_W'(1) : r_err_cnt;

    // Reload the settle timer whenever a new vector is about to be driven
`ifdef DEMOG_CONT_SWEEP_EN
    assign w_tmr_load = ((r_state == IDLE) && start)
                     || ((r_state == SAMPLE) && (r_vec != LAST_VEC))
                     || (r_state == DONE);
`else
    assign w_tmr_load = ((r_state == IDLE) && start)
                     || ((r_state == SAMPLE) && (r_vec != LAST_VEC));
`endif
    assign w_tmr_en = (r_state == SETTLE);

    demog_settle_timer #(
        .W (SETTLE_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_en       (w_tmr_en),
        .i_load_val (SETTLE_RLD),
        .o_zero_c   (w_tmr_zero)
    );

    // Sweep sequencer with registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_vec         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_err_cnt     <= '0;
            r_first_vec   <= '0;
            r_first_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec         <= '0;
                        r_err_cnt     <= '0;
                        r_first_valid <= 1'b0;
                        r_pass        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_tmr_zero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_err_cnt <= w_err_next;
                    if (w_mismatch && !r_first_valid) begin
                        r_first_vec   <= r_vec;
                        r_first_valid <= 1'b1;
                    end
                    if (r_vec == LAST_VEC) begin
                        // Verdict uses the count including this vector's result
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                        r_state <= DONE;
                    end else begin
                        r_vec   <= r_vec + VEC_W'(1);
                        r_state <= SETTLE;
                    end
                end
                DONE: begin
                    r_done <= 1'b0;
`ifdef DEMOG_CONT_SWEEP_EN
                    r_vec         <= '0;
                    r_err_cnt     <= '0;
                    r_first_valid <= 1'b0;
                    r_state       <= SETTLE;
`else
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
`endif
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dut_a           = r_vec[2];
    assign dut_b           = r_vec[1];
    assign dut_c           = r_vec[0];
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_cnt         = r_err_cnt;
    assign first_err_vec   = r_first_vec;
    assign first_err_valid = r_first_valid;

endmodule
